rgb_downscale_2x2: RTL and testbench
====================================

Name: rgb_downscale_2x2

Overview:
- Downstream of the RGB565 deserializer; consumes its 16-bit pixel stream plus HREF/VSYNC framing.
- Box-filters every 2x2 pixel block into one RGB565 pixel, giving a half-resolution frame (640x480 -> 320x240).
- Uses one half-width line buffer.
- Emits pixel, data-valid, write address and x/y for the downstream video memory writer.

Parameters:
RESOLUTION_WIDTH, 640, input pixels per line; must be even.
RESOLUTION_HEIGHT, 480, input lines per frame; must be even.

Ports:
PCLK  input  1  pixel clock; all state on rising edge
RST_N  input  1  asynchronous active-low reset
i_RGB  input  16  RGB565 pixel {R[15:11],G[10:5],B[4:0]}, valid when i_DV=1
i_DV  input  1  one-cycle strobe per input pixel
HREF  input  1  line active; falling edge ends a line
VSYNC  input  1  high = vertical blanking; clears frame state
o_RGB  output  16  averaged RGB565 pixel
o_DV  output  1  one-cycle strobe per output pixel
o_w_addr  output  $clog2(W*H/4)  output raster address, y_out*(W/2)+x_out
o_pixel_x  output  $clog2(W/2)  output column
o_pixel_y  output  $clog2(H/2)  output row

Behaviour:
- Reset (RST_N=0, async):
  - All outputs 0.
  - col=0, row=0, phase=H_EVEN, pending-left-pixel cleared.
  - Line buffer contents not reset (always written before read).
- Counters:
  - col counts i_DV pulses within a line.
  - row counts HREF falling edges, detected with a registered HREF.
  - VSYNC=1 forces col=0, row=0, phase=H_EVEN and drops any held pixel.
- Horizontal FSM, states H_EVEN / H_ODD, advanced only on i_DV with col<W:
  - H_EVEN: latch R,G,B of i_RGB into hold register; go to H_ODD.
  - H_ODD: form pair sums Rs = R0+R1 (6b), Gs (7b), Bs (6b); go to H_EVEN.
- HREF falling edge:
  - col=0, row+1, phase=H_EVEN.
  - A held, unpaired pixel (odd pixel count) is discarded.
- Even rows (row[0]=0): on H_ODD completion, write {Rs,Gs,Bs} (19b) into line buffer at index col>>1. No output.
- Odd rows (row[0]=1):
  - Line buffer read address col>>1 is presented while in H_ODD, so data is available at pair completion.
  - On H_ODD completion, totals: Rt = Rs+Rbuf (7b), Gt (8b), Bt (7b).
  - Result {Rt>>2, Gt>>2, Bt>>2} is packed to RGB565; see Optional Feature for rounding.
  - No overflow is possible: max 4*31+2=126, 4*63+2=254.
- Output timing:
  - o_DV, o_RGB, o_w_addr, o_pixel_x=col>>1 and o_pixel_y=row>>1 are registered.
  - They appear 1 cycle after the i_DV of the second pixel of the odd-row pair.
  - o_DV is high exactly one cycle; the other outputs hold their value until the next output.
- Bounds:
  - i_DV with col>=W is ignored; col saturates at W.
  - Lines with row>=H are ignored (no buffer write, no output).
- Simultaneous events:
  - i_DV in the same cycle as an HREF falling-edge detect: the pixel is processed first, with pre-edge col/row; the edge takes effect the next cycle.
  - VSYNC=1 overrides i_DV (pixel dropped).
- Reset mid-frame: outputs return to 0 immediately; the first valid output resumes after the next complete odd row of a fresh frame.

Optional Feature:
- Macro DOWNSCALE_ROUND_EN.
- Defined: add 2 to Rt, Gt, Bt before >>2 (round half up).
- Undefined: plain truncation (>>2). Adder widths are unchanged in both cases.

Test Plan:
- Uniform frame, all pixels 16'hFFFF, 640x480 -> 76800 o_DV pulses, all o_RGB=16'hFFFF, o_w_addr 0..76799 in order, last x=319, y=239.
- Block with input pixels 0x0000,0x0841,0x0841,0x0841 (R=1,G=2,B=1 for three) -> with rounding o_RGB={R=1,G=2,B=1}=0x0841; without rounding {R=0,G=1,B=0}=0x0020.
- Output latency: second odd-row pixel i_DV at cycle N -> o_DV=1 at N+1 only, o_pixel_x=col>>1, o_pixel_y=0 for rows 0/1.
- Line with 641 i_DV pulses -> last pixel ignored, 320 outputs on that row pair; line with 5 pulses -> 2 outputs, trailing pixel dropped.
- VSYNC pulsed high mid-row-3 -> no further o_DV; next frame's first output has o_w_addr=0, x=0, y=0.
- RST_N low for 1 cycle during odd row -> all outputs 0 asynchronously; no o_DV until a full even+odd row pair completes after reset.

Source files
------------

// File: rtl/rgb_downscale_2x2.sv
`default_nettype none
// ============================================================================
// Module   : rgb_downscale_2x2
// Purpose  : 2x2 box-filter downscaler for an RGB565 pixel stream with HREF/VSYNC
//            framing. Uses one half-width line buffer of horizontal pair sums.
//            Optional macro DOWNSCALE_ROUND_EN selects round-half-up averaging.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_downscale_2x2 #(
    parameter int RESOLUTION_WIDTH  = 640,
    parameter int RESOLUTION_HEIGHT = 480
) (
    input  logic                                                     PCLK,
    input  logic                                                     RST_N,
    input  logic [15:0]                                              i_RGB,
    input  logic                                                     i_DV,
    input  logic                                                     HREF,
    input  logic                                                     VSYNC,
    output logic [15:0]                                              o_RGB,
    output logic                                                     o_DV,
    output logic [$clog2(RESOLUTION_WIDTH*RESOLUTION_HEIGHT/4)-1:0]  o_w_addr,
    output logic [$clog2(RESOLUTION_WIDTH/2)-1:0]                    o_pixel_x,
    output logic [$clog2(RESOLUTION_HEIGHT/2)-1:0]                   o_pixel_y
);

    localparam int c_HALF_W = RESOLUTION_WIDTH / 2;
    localparam int c_COL_W  = $clog2(RESOLUTION_WIDTH + 1);
    localparam int c_ROW_W  = $clog2(RESOLUTION_HEIGHT + 1);
    localparam int c_X_W    = $clog2(RESOLUTION_WIDTH / 2);
    localparam int c_Y_W    = $clog2(RESOLUTION_HEIGHT / 2);
    localparam int c_A_W    = $clog2(RESOLUTION_WIDTH * RESOLUTION_HEIGHT / 4);

    localparam logic [c_COL_W-1:0] c_COL_MAX  = c_COL_W'(RESOLUTION_WIDTH);
    localparam logic [c_ROW_W-1:0] c_ROW_MAX  = c_ROW_W'(RESOLUTION_HEIGHT);
    localparam logic [c_A_W-1:0]   c_HALF_W_A = c_A_W'(c_HALF_W);

    typedef enum logic [0:0] {
        H_EVEN = 1'b0,
        H_ODD  = 1'b1
    } h_state_t;

    h_state_t             r_phase;
    logic [c_COL_W-1:0]   r_col;
    logic [c_ROW_W-1:0]   r_row;
    logic                 r_href_d;
    logic [4:0]           r_hold_r;
    logic [5:0]           r_hold_g;
    logic [4:0]           r_hold_b;
    logic [18:0]          r_rd_data;

    // Line buffer entry layout: {Rs[5:0], Gs[6:0], Bs[5:0]}
    logic [18:0]          r_line_buf [0:c_HALF_W-1];

    logic                 w_pix_ok;
    logic                 w_row_ok;
    logic                 w_href_fall;
    logic                 w_pair_done;
    logic [c_X_W-1:0]     w_pair_idx;
    logic [c_Y_W-1:0]     w_out_y;
    logic [c_A_W-1:0]     w_addr;
    logic [5:0]           w_rs;
    logic [6:0]           w_gs;
    logic [5:0]           w_bs;
    logic [6:0]           w_rt;
    logic [7:0]           w_gt;
    logic [6:0]           w_bt;
    logic [6:0]           w_rt_f;
    logic [7:0]           w_gt_f;
    logic [6:0]           w_bt_f;
    logic [15:0]          w_avg;

    assign w_pix_ok    = i_DV & ~VSYNC & (r_col < c_COL_MAX);
    assign w_row_ok    = (r_row < c_ROW_MAX);
    assign w_href_fall = r_href_d & ~HREF;
    assign w_pair_done = w_pix_ok & (r_phase == H_ODD);
    assign w_pair_idx  = r_col[c_X_W:1];
    assign w_out_y     = r_row[c_Y_W:1];
    assign w_addr      = c_A_W'(w_out_y) * c_HALF_W_A + c_A_W'(w_pair_idx);

    assign w_rs = {1'b0, r_hold_r} + {1'b0, i_RGB[15:11]};
    assign w_gs = {1'b0, r_hold_g} + {1'b0, i_RGB[10:5]};
    assign w_bs = {1'b0, r_hold_b} + {1'b0, i_RGB[4:0]};

    assign w_rt = {1'b0, w_rs} + {1'b0, r_rd_data[18:13]};
    assign w_gt = {1'b0, w_gs} + {1'b0, r_rd_data[12:6]};
    assign w_bt = {1'b0, w_bs} + {1'b0, r_rd_data[5:0]};

`ifdef DOWNSCALE_ROUND_EN
    assign w_rt_f = w_rt + 7'd2;
    assign w_gt_f = w_gt + 8'd2;
    assign w_bt_f = w_bt + 7'd2;
`else
    assign w_rt_f = w_rt;
    assign w_gt_f = w_gt;
    assign w_bt_f = w_bt;
`endif

    assign w_avg = {w_rt_f[6:2], w_gt_f[7:2], w_bt_f[6:2]};

    // The pair index is the same for both pixels of a pair, so reading every
    // cycle makes the upper-row sum ready by the time the pair completes.
    always_ff @(posedge PCLK) begin
        r_rd_data <= r_line_buf[w_pair_idx];
        if (w_pair_done && w_row_ok && !r_row[0]) begin
            r_line_buf[w_pair_idx] <= {w_rs, w_gs, w_bs};
        end
    end

    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_phase   <= H_EVEN;
            r_col     <= '0;
            r_row     <= '0;
            r_href_d  <= 1'b0;
            r_hold_r  <= '0;
            r_hold_g  <= '0;
            r_hold_b  <= '0;
            o_RGB     <= '0;
            o_DV      <= 1'b0;
            o_w_addr  <= '0;
            o_pixel_x <= '0;
            o_pixel_y <= '0;
        end else begin
            r_href_d <= HREF;
            o_DV     <= 1'b0;

            // Output uses pre-edge col/row even when a line edge lands this cycle
            if (w_pair_done && w_row_ok && r_row[0]) begin
                o_DV      <= 1'b1;
                o_RGB     <= w_avg;
                o_w_addr  <= w_addr;
                o_pixel_x <= w_pair_idx;
                o_pixel_y <= w_out_y;
            end

            if (w_pix_ok && r_phase == H_EVEN) begin
                r_hold_r <= i_RGB[15:11];
                r_hold_g <= i_RGB[10:5];
                r_hold_b <= i_RGB[4:0];
            end

            if (VSYNC) begin
                r_col   <= '0;
                r_row   <= '0;
                r_phase <= H_EVEN;
            end else if (w_href_fall) begin
                r_col   <= '0;
                r_phase <= H_EVEN;
                if (w_row_ok) begin
                    r_row <= r_row + c_ROW_W'(1);
                end
            end else if (w_pix_ok) begin
                r_col <= r_col + c_COL_W'(1);
                case (r_phase)
                    H_EVEN:  r_phase <= H_ODD;
                    H_ODD:   r_phase <= H_EVEN;
                    default: r_phase <= H_EVEN;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rgb_downscale_2x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_downscale_2x2
// Purpose  : Directed self-checking bench for rgb_downscale_2x2 (640x480).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_downscale_2x2;

    localparam int W   = 640;
    localparam int H   = 480;
    localparam int A_W = $clog2(W * H / 4);
    localparam int X_W = $clog2(W / 2);
    localparam int Y_W = $clog2(H / 2);

`ifdef DOWNSCALE_ROUND_EN
    localparam logic [15:0] c_EXP_A = 16'h0841;
    localparam logic [15:0] c_EXP_C = 16'h0217;
    localparam logic [15:0] c_EXP_5 = 16'h8410;
`else
    localparam logic [15:0] c_EXP_A = 16'h0020;
    localparam logic [15:0] c_EXP_C = 16'h01F7;
    localparam logic [15:0] c_EXP_5 = 16'h7BEF;
`endif
    localparam logic [15:0] c_EXP_B = 16'hB800;

    logic            PCLK = 1'b0;
    logic            RST_N;
    logic [15:0]     i_RGB;
    logic            i_DV;
    logic            HREF;
    logic            VSYNC;
    logic [15:0]     o_RGB;
    logic            o_DV;
    logic [A_W-1:0]  o_w_addr;
    logic [X_W-1:0]  o_pixel_x;
    logic [Y_W-1:0]  o_pixel_y;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [15:0] q_rgb[$];
    int          q_addr[$];
    int          q_x[$];
    int          q_y[$];
    int          q_cyc[$];
    int          drv_cyc[$];

    rgb_downscale_2x2 #(
        .RESOLUTION_WIDTH (W),
        .RESOLUTION_HEIGHT(H)
    ) dut (
        .PCLK     (PCLK),
        .RST_N    (RST_N),
        .i_RGB    (i_RGB),
        .i_DV     (i_DV),
        .HREF     (HREF),
        .VSYNC    (VSYNC),
        .o_RGB    (o_RGB),
        .o_DV     (o_DV),
        .o_w_addr (o_w_addr),
        .o_pixel_x(o_pixel_x),
        .o_pixel_y(o_pixel_y)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    always @(negedge PCLK) begin
        if (o_DV === 1'b1) begin
            q_rgb.push_back(o_RGB);
            q_addr.push_back(int'(o_w_addr));
            q_x.push_back(int'(o_pixel_x));
            q_y.push_back(int'(o_pixel_y));
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        q_rgb.delete(); q_addr.delete(); q_x.delete(); q_y.delete(); q_cyc.delete();
    endtask

    // Fill missing captures with impossible values so indexed checks fail cleanly
    task automatic pad(input int n);
        while (q_rgb.size() < n) begin
            q_rgb.push_back(16'hxxxx); q_addr.push_back(-1); q_x.push_back(-1);
            q_y.push_back(-1); q_cyc.push_back(-1);
        end
    endtask

    task automatic idle(input int n);
        i_DV = 1'b0;
        repeat (n) @(negedge PCLK);
    endtask

    task automatic pix(input logic [15:0] v, input logic href_v);
        i_DV  = 1'b1;
        i_RGB = v;
        HREF  = href_v;
        drv_cyc.push_back(cyc);
        @(negedge PCLK);
        i_DV  = 1'b0;
    endtask

    task automatic end_line();
        HREF = 1'b0;
        idle(4);
    endtask

    task automatic line_const(input int n, input logic [15:0] v);
        HREF = 1'b1;
        idle(1);
        for (int i = 0; i < n; i++) pix(v, 1'b1);
        end_line();
    endtask

    task automatic vsync_pulse();
        VSYNC = 1'b1;
        idle(3);
        VSYNC = 1'b0;
        idle(2);
    endtask

    initial begin
        int bad_rgb, bad_addr, bad_xy, n;
        logic [15:0] blk_r0 [6];
        logic [15:0] blk_r1 [6];
        blk_r0 = '{16'h0000, 16'h0841, 16'hF800, 16'h0000, 16'h001F, 16'h07E0};
        blk_r1 = '{16'h0841, 16'h0841, 16'hF800, 16'hF800, 16'h001F, 16'h001F};

        RST_N = 1'b0; HREF = 1'b0; VSYNC = 1'b0; i_DV = 1'b0; i_RGB = 16'h0000;
        @(negedge PCLK);
        chk("rst_dv",   32'(o_DV),      0);
        chk("rst_rgb",  32'(o_RGB),     0);
        chk("rst_addr", 32'(o_w_addr),  0);
        chk("rst_x",    32'(o_pixel_x), 0);
        chk("rst_y",    32'(o_pixel_y), 0);
        idle(2);
        RST_N = 1'b1;
        idle(2);

        // Uniform white, two row pairs, back-to-back pixels
        vsync_pulse();
        clear_q();
        for (int r = 0; r < 4; r++) line_const(W, 16'hFFFF);
        chk("uni_count", q_rgb.size(), 640);
        pad(640);
        bad_rgb = 0; bad_addr = 0; bad_xy = 0;
        for (int i = 0; i < 640; i++) begin
            if (q_rgb[i] !== 16'hFFFF) bad_rgb++;
            if (q_addr[i] != i) bad_addr++;
            if (q_x[i] != i % 320 || q_y[i] != i / 320) bad_xy++;
        end
        chk("uni_rgb_bad",  bad_rgb,  0);
        chk("uni_addr_bad", bad_addr, 0);
        chk("uni_xy_bad",   bad_xy,   0);
        chk("uni_last_x",   q_x[639], 319);
        chk("uni_last_y",   q_y[639], 1);

        // Hand-computed blocks with idle gaps; latency from row-1 pixel strobes
        vsync_pulse();
        clear_q();
        HREF = 1'b1; idle(1);
        for (int i = 0; i < 6; i++) begin pix(blk_r0[i], 1'b1); idle(1); end
        end_line();
        drv_cyc.delete();
        HREF = 1'b1; idle(1);
        for (int i = 0; i < 6; i++) begin pix(blk_r1[i], 1'b1); idle(1); end
        end_line();
        chk("blk_count", q_rgb.size(), 3);
        pad(3);
        chk("blk0_rgb",  32'(q_rgb[0]), 32'(c_EXP_A));
        chk("blk1_rgb",  32'(q_rgb[1]), 32'(c_EXP_B));
        chk("blk2_rgb",  32'(q_rgb[2]), 32'(c_EXP_C));
        chk("blk0_x",    q_x[0], 0);
        chk("blk0_y",    q_y[0], 0);
        chk("blk2_x",    q_x[2], 2);
        chk("blk2_addr", q_addr[2], 2);
        chk("blk0_lat",  q_cyc[0], drv_cyc[1] + 1);
        chk("blk2_lat",  q_cyc[2], drv_cyc[5] + 1);

        // 641-pulse lines, then 5-pulse line and a line ending on an edge-coincident pixel
        vsync_pulse();
        clear_q();
        line_const(W + 1, 16'h0841);
        line_const(W + 1, 16'h0841);
        chk("ovf_count", q_rgb.size(), 320);
        pad(320);
        chk("ovf_last_x",   q_x[319], 319);
        chk("ovf_last_y",   q_y[319], 0);
        chk("ovf_last_rgb", 32'(q_rgb[319]), 32'h0841);
        clear_q();
        HREF = 1'b1; idle(1);
        for (int i = 0; i < 4; i++) pix(16'hFFFF, 1'b1);
        pix(16'hF800, 1'b1);
        end_line();
        HREF = 1'b1; idle(1);
        for (int i = 0; i < 3; i++) pix(16'h0000, 1'b1);
        pix(16'h0000, 1'b0);
        end_line();
        chk("short_count", q_rgb.size(), 2);
        pad(2);
        chk("short0_rgb",  32'(q_rgb[0]), 32'(c_EXP_5));
        chk("short1_rgb",  32'(q_rgb[1]), 32'(c_EXP_5));
        chk("short1_x",    q_x[1], 1);
        chk("short1_y",    q_y[1], 1);
        chk("short1_addr", q_addr[1], 321);

        // VSYNC in the middle of row 3
        vsync_pulse();
        clear_q();
        for (int r = 0; r < 3; r++) line_const(4, 16'hFFFF);
        HREF = 1'b1; idle(1);
        pix(16'hFFFF, 1'b1); pix(16'hFFFF, 1'b1);
        VSYNC = 1'b1;
        pix(16'hFFFF, 1'b1); pix(16'hFFFF, 1'b1);
        HREF = 1'b0; idle(2);
        VSYNC = 1'b0; idle(4);
        chk("vs_count", q_rgb.size(), 3);
        line_const(2, 16'h0841);
        line_const(2, 16'h0841);
        chk("vs_new_count", q_rgb.size(), 4);
        pad(4);
        chk("vs_new_addr", q_addr[3], 0);
        chk("vs_new_x",    q_x[3], 0);
        chk("vs_new_y",    q_y[3], 0);
        chk("vs_new_rgb",  32'(q_rgb[3]), 32'h0841);

        // Asynchronous reset during an odd row
        vsync_pulse();
        clear_q();
        for (int r = 0; r < 3; r++) line_const(4, 16'hFFFF);
        HREF = 1'b1; idle(1);
        pix(16'hFFFF, 1'b1);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_rgb",  32'(o_RGB),     0);
        chk("arst_addr", 32'(o_w_addr),  0);
        chk("arst_x",    32'(o_pixel_x), 0);
        chk("arst_y",    32'(o_pixel_y), 0);
        @(negedge PCLK);
        RST_N = 1'b1;
        clear_q();
        for (int i = 0; i < 3; i++) pix(16'hFFFF, 1'b1);
        end_line();
        vsync_pulse();
        chk("arst_quiet", q_rgb.size(), 0);
        line_const(2, 16'hFFFF);
        line_const(2, 16'h0000);
        chk("arst_resume_count", q_rgb.size(), 1);
        pad(1);
        chk("arst_resume_rgb",  32'(q_rgb[0]), 32'(c_EXP_5));
        chk("arst_resume_addr", q_addr[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
